kia_scan_decoder: RTL and testbench

Bus-master stage that sits directly downstream of the KIA keyboard queue. It polls the KIA over its Wishbone slave port, pops each received PS/2 byte, and decodes scan-code set 2 prefix sequences (E0, F0, E1) into single key events that carry live modifier state. Events are presented on a valid/ack port to the next consumer. Backpressure on that port stalls polling, so unread bytes stay in the KIA queue.

---
 rtl/kia_scan_decoder.sv | 158 +++++++++++++++
 tb/tb_kia_scan_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kia_scan_decoder.sv
// Polls the KIA keyboard queue over Wishbone, pops each byte and folds scan-code
// set 2 prefix sequences into single key events that carry live modifier state.
module kia_scan_decoder (
   input  logic        CLK_I,
   input  logic        RES_I,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   output logic        ADR_O,
   input  logic        ACK_I,
   input  logic [7:0]  DAT_I,
   output logic        EV_VALID_O,
   output logic [15:0] EV_DAT_O,
   input  logic        EV_ACK_I
);

   typedef enum logic [2:0] {
      ST_STAT, ST_STAT_GAP, ST_DATA, ST_DATA_GAP, ST_POP, ST_POP_GAP, ST_EMIT
   } state_t;

   state_t      state_r, state_nx;
   logic        empty_r;
   logic [7:0]  byte_r;
   logic [15:0] ev_word_r;
   logic        ext_r, brk_r;
   logic [2:0]  skip_r;
   logic        lshift_r, rshift_r, lctrl_r, rctrl_r, lalt_r, ralt_r, caps_r;

   logic        ext_nx, brk_nx;
   logic [2:0]  skip_nx;
   logic        lshift_nx, rshift_nx, lctrl_nx, rctrl_nx, lalt_nx, ralt_nx, caps_nx;
   logic        dec_emit, word_brk, word_ext;
   logic [7:0]  word_code;
   logic [15:0] dec_word;

   // Byte decoder; its results are committed only in POP_GAP.
   always_comb begin
      ext_nx    = ext_r;
      brk_nx    = brk_r;
      skip_nx   = skip_r;
      lshift_nx = lshift_r;
      rshift_nx = rshift_r;
      lctrl_nx  = lctrl_r;
      rctrl_nx  = rctrl_r;
      lalt_nx   = lalt_r;
      ralt_nx   = ralt_r;
      caps_nx   = caps_r;
      dec_emit  = 1'b0;
      word_brk  = brk_r;
      word_ext  = ext_r;
      word_code = byte_r;
      if (skip_r != 3'd0) begin
         skip_nx = skip_r - 3'd1;
         if (skip_r == 3'd1) begin
            dec_emit  = 1'b1;
            word_brk  = 1'b0;
            word_ext  = 1'b0;
            word_code = 8'hE1;
         end
      end else if (byte_r == 8'hE1) begin
         skip_nx = 3'd7;
      end else if (byte_r == 8'hE0) begin
         ext_nx = 1'b1;
      end else if (byte_r == 8'hF0) begin
         brk_nx = 1'b1;
      end else if (byte_r == 8'h00 || byte_r == 8'hAA || byte_r == 8'hEE ||
                   byte_r == 8'hFA || byte_r == 8'hFE || byte_r == 8'hFF) begin
         ext_nx = 1'b0;
         brk_nx = 1'b0;
      end else begin
         case (byte_r)
            8'h12: if (!ext_r) lshift_nx = !brk_r;
            8'h59: if (!ext_r) rshift_nx = !brk_r;
            8'h14: if (!ext_r) lctrl_nx = !brk_r; else rctrl_nx = !brk_r;
            8'h11: if (!ext_r) lalt_nx = !brk_r; else ralt_nx = !brk_r;
            8'h58: if (!ext_r && !brk_r) caps_nx = !caps_r;
            default: ;
         endcase
         dec_emit = 1'b1;
         ext_nx   = 1'b0;
         brk_nx   = 1'b0;
      end
      dec_word = {word_brk, word_ext, 2'b00, caps_nx, lalt_nx | ralt_nx,
                  lctrl_nx | rctrl_nx, lshift_nx | rshift_nx, word_code};
   end

   always_ff @(posedge CLK_I) begin
      if (RES_I) state_r <= ST_STAT_GAP;
      else       state_r <= state_nx;
   end

   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_STAT:     if (ACK_I) state_nx = ST_STAT_GAP;
         ST_STAT_GAP: state_nx = empty_r ? ST_STAT : ST_DATA;
         ST_DATA:     if (ACK_I) state_nx = ST_DATA_GAP;
         ST_DATA_GAP: state_nx = ST_POP;
         ST_POP:      if (ACK_I) state_nx = ST_POP_GAP;
         ST_POP_GAP:  state_nx = dec_emit ? ST_EMIT : ST_STAT;
         ST_EMIT:     if (EV_ACK_I) state_nx = ST_STAT;
         default:     state_nx = ST_STAT_GAP;
      endcase
   end

   always_comb begin
      CYC_O      = 1'b0;
      STB_O      = 1'b0;
      WE_O       = 1'b0;
      ADR_O      = 1'b0;
      EV_VALID_O = 1'b0;
      case (state_r)
         ST_STAT: begin CYC_O = 1'b1; STB_O = 1'b1; end
         ST_DATA: begin CYC_O = 1'b1; STB_O = 1'b1; ADR_O = 1'b1; end
         ST_POP:  begin CYC_O = 1'b1; STB_O = 1'b1; ADR_O = 1'b1; WE_O = 1'b1; end
         ST_EMIT: EV_VALID_O = 1'b1;
         default: ;
      endcase
   end

   assign EV_DAT_O = ev_word_r;

   // empty_r resets to 1 so the post-reset gap falls through to a status read.
   always_ff @(posedge CLK_I) begin
      if (RES_I) begin
         empty_r   <= 1'b1;
         byte_r    <= 8'h00;
         ev_word_r <= 16'h0000;
         ext_r     <= 1'b0;
         brk_r     <= 1'b0;
         skip_r    <= 3'd0;
         lshift_r  <= 1'b0;
         rshift_r  <= 1'b0;
         lctrl_r   <= 1'b0;
         rctrl_r   <= 1'b0;
         lalt_r    <= 1'b0;
         ralt_r    <= 1'b0;
         caps_r    <= 1'b0;
      end else begin
         if (state_r == ST_STAT && ACK_I) empty_r <= DAT_I[0];
         if (state_r == ST_DATA && ACK_I) byte_r <= DAT_I;
         if (state_r == ST_POP_GAP) begin
            ext_r    <= ext_nx;
            brk_r    <= brk_nx;
            skip_r   <= skip_nx;
            lshift_r <= lshift_nx;
            rshift_r <= rshift_nx;
            lctrl_r  <= lctrl_nx;
            rctrl_r  <= rctrl_nx;
            lalt_r   <= lalt_nx;
            ralt_r   <= ralt_nx;
            caps_r   <= caps_nx;
            if (dec_emit) ev_word_r <= dec_word;
         end
      end
   end

endmodule

// File: tb/tb_kia_scan_decoder.sv
// Bench for kia_scan_decoder: a one-cycle KIA queue model feeds bytes, and a
// key-table reference model predicts the event stream.
module tb_kia_scan_decoder;

   logic        CLK_I = 1'b0;
   logic        RES_I;
   logic        CYC_O, STB_O, WE_O, ADR_O;
   logic        ACK_I;
   logic [7:0]  DAT_I;
   logic        EV_VALID_O;
   logic [15:0] EV_DAT_O;
   logic        EV_ACK_I;

   kia_scan_decoder dut (
      .CLK_I(CLK_I), .RES_I(RES_I),
      .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
      .ACK_I(ACK_I), .DAT_I(DAT_I),
      .EV_VALID_O(EV_VALID_O), .EV_DAT_O(EV_DAT_O), .EV_ACK_I(EV_ACK_I)
   );

   always #5 CLK_I = ~CLK_I;

   int n_checks = 0;
   int n_errors = 0;

   // KIA queue model: registered ACK, combinational pop on ACK & WE & ADR.
   logic [7:0] mem [256];
   int         rd_ptr = 0;
   int         wr_ptr = 0;
   int         pop_count = 0;
   int         bad_pops = 0;
   logic       kia_ack = 1'b0;

   always @(posedge CLK_I) begin
      if (ACK_I && WE_O && ADR_O) begin
         if (rd_ptr == wr_ptr) bad_pops <= bad_pops + 1;
         else rd_ptr <= rd_ptr + 1;
         pop_count <= pop_count + 1;
      end
      kia_ack <= CYC_O & STB_O;
   end

   assign ACK_I = kia_ack;
   assign DAT_I = ADR_O ? mem[rd_ptr[7:0]] : {7'b0, rd_ptr == wr_ptr};

   // Reference model: a table of held keys keyed by {E0 prefix, code}.
   bit          held [int];
   bit          m_ext, m_brk, m_caps;
   int          pause_left;
   logic [15:0] exp_q [$];
   bit          auto_ack;

   function automatic bit isHeld(int key);
      return held.exists(key) ? held[key] : 1'b0;
   endfunction

   function automatic void modelReset();
      held.delete();
      m_ext = 0; m_brk = 0; m_caps = 0; pause_left = 0;
   endfunction

   function automatic void modelByte(logic [7:0] b);
      int  key;
      bit  shift, ctrl, alt;
      if (pause_left > 0) begin
         pause_left--;
         if (pause_left == 0) begin
            shift = isHeld('h12) | isHeld('h59);
            ctrl  = isHeld('h14) | isHeld('hE014);
            alt   = isHeld('h11) | isHeld('hE011);
            exp_q.push_back({1'b0, 1'b0, 2'b00, m_caps, alt, ctrl, shift, 8'hE1});
         end
         return;
      end
      case (b)
         8'hE1: pause_left = 7;
         8'hE0: m_ext = 1;
         8'hF0: m_brk = 1;
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin m_ext = 0; m_brk = 0; end
         default: begin
            key = m_ext ? ('hE000 + int'(b)) : int'(b);
            if (key == 'h12 || key == 'h59 || key == 'h14 || key == 'hE014 ||
                key == 'h11 || key == 'hE011)
               held[key] = !m_brk;
            if (key == 'h58 && !m_brk) m_caps = !m_caps;
            shift = isHeld('h12) | isHeld('h59);
            ctrl  = isHeld('h14) | isHeld('hE014);
            alt   = isHeld('h11) | isHeld('hE011);
            exp_q.push_back({m_brk, m_ext, 2'b00, m_caps, alt, ctrl, shift, b});
            m_ext = 0; m_brk = 0;
         end
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   // One cycle; the consumer randomly accepts and checks events when auto_ack is set.
   task automatic step();
      bit take;
      @(negedge CLK_I);
      if (auto_ack) begin
         take = 1'b0;
         if (EV_VALID_O) begin
            take = ($urandom_range(0, 2) != 0);
            if (take) begin
               if (exp_q.size() == 0) checkOutput("unexpected_event", {16'h0, EV_DAT_O}, 32'hFFFFFFFF);
               else checkOutput("event", {16'h0, EV_DAT_O}, {16'h0, exp_q.pop_front()});
            end
         end
         EV_ACK_I = take;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit use_model);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
      if (use_model) modelByte(b);
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 4000 && !done; i++) begin
         if (exp_q.size() == 0 && rd_ptr == wr_ptr && !EV_VALID_O) done = 1;
         else step();
      end
      checkOutput("drain_timeout", {31'b0, done}, 32'd1);
      repeat (12) step();
      checkOutput("drain_left", exp_q.size(), 32'd0);
   endtask

   function automatic logic [7:0] randomByte();
      logic [7:0] pool [16] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h75, 8'hE0,
                                8'hF0, 8'hF0, 8'hE0, 8'hFA, 8'hAA, 8'h77, 8'h1C, 8'hE1};
      if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 255));
      return pool[$urandom_range(0, 15)];
   endfunction

   initial begin
      bit found;
      int pops0;
      RES_I = 1'b1;
      EV_ACK_I = 1'b0;
      auto_ack = 0;
      modelReset();
      repeat (3) step();
      checkOutput("reset_bus", {27'b0, CYC_O, STB_O, WE_O, ADR_O, EV_VALID_O}, 32'd0);
      checkOutput("reset_word", {16'h0, EV_DAT_O}, 32'd0);
      RES_I = 1'b0;

      // Empty queue: status polls repeat 1,1,0 and never touch data.
      found = 0;
      for (int i = 0; i < 5 && !found; i++) begin
         step();
         if (CYC_O) found = 1;
      end
      checkOutput("first_poll", {31'b0, found}, 32'd1);
      for (int i = 0; i < 12; i++) begin
         checkOutput("poll_cyc", {31'b0, CYC_O}, (i % 3 != 2) ? 32'd1 : 32'd0);
         checkOutput("poll_adr", {31'b0, ADR_O}, 32'd0);
         checkOutput("poll_valid", {31'b0, EV_VALID_O}, 32'd0);
         step();
      end

      // Single 1C, consumer holds off: event at c9, word and bus frozen.
      pops0 = pop_count;
      applyStimulus(8'h1C, 0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (STB_O && ADR_O && !WE_O) found = 1;
      end
      checkOutput("data_read_seen", {31'b0, found}, 32'd1);
      repeat (5) step();
      checkOutput("c8_valid", {31'b0, EV_VALID_O}, 32'd0);
      step();
      checkOutput("c9_valid", {31'b0, EV_VALID_O}, 32'd1);
      checkOutput("c9_word", {16'h0, EV_DAT_O}, 32'h001C);
      for (int i = 0; i < 20; i++) begin
         step();
         checkOutput("hold_valid", {31'b0, EV_VALID_O}, 32'd1);
         checkOutput("hold_word", {16'h0, EV_DAT_O}, 32'h001C);
         checkOutput("hold_bus_idle", {31'b0, CYC_O}, 32'd0);
      end
      checkOutput("hold_pops", pop_count - pops0, 32'd1);
      EV_ACK_I = 1'b1;
      step();
      checkOutput("ack_valid_drop", {31'b0, EV_VALID_O}, 32'd0);
      checkOutput("ack_stb_rise", {31'b0, STB_O}, 32'd1);
      EV_ACK_I = 1'b0;

      // Directed sequences through the model.
      auto_ack = 1;
      applyStimulus(8'h12, 1); applyStimulus(8'h1C, 1);
      applyStimulus(8'hF0, 1); applyStimulus(8'h1C, 1);
      applyStimulus(8'hF0, 1); applyStimulus(8'h12, 1);
      checkOutput("model_plain", {exp_q[0], exp_q[1]}, 32'h0112011C);
      checkOutput("model_break", {exp_q[2], exp_q[3]}, 32'h811C8012);
      drain();
      applyStimulus(8'hE0, 1); applyStimulus(8'hF0, 1); applyStimulus(8'h75, 1);
      applyStimulus(8'hE0, 1); applyStimulus(8'h12, 1);
      applyStimulus(8'hE0, 1); applyStimulus(8'h14, 1);
      checkOutput("model_ext", {exp_q[0], exp_q[1]}, 32'hC0754012);
      drain();
      applyStimulus(8'hE0, 1); applyStimulus(8'hF0, 1); applyStimulus(8'h14, 1);
      applyStimulus(8'h58, 1); applyStimulus(8'hF0, 1); applyStimulus(8'h58, 1);
      applyStimulus(8'h58, 1);
      applyStimulus(8'hFA, 1);
      applyStimulus(8'hE0, 1); applyStimulus(8'hFA, 1); applyStimulus(8'h1C, 1);
      checkOutput("model_caps", {exp_q[1], exp_q[2]}, 32'h08588858);
      drain();
      applyStimulus(8'hE1, 1); applyStimulus(8'h14, 1); applyStimulus(8'h77, 1);
      applyStimulus(8'hE1, 1); applyStimulus(8'hF0, 1); applyStimulus(8'h14, 1);
      applyStimulus(8'hF0, 1); applyStimulus(8'h77, 1);
      checkOutput("model_pause", {exp_q.size(), exp_q[0]}, {16'd1, 16'h00E1});
      drain();

      // Reset during POP: shift held beforehand must be gone afterwards.
      applyStimulus(8'h12, 1);
      drain();
      applyStimulus(8'h1C, 1);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (WE_O) found = 1;
      end
      checkOutput("pop_seen", {31'b0, found}, 32'd1);
      RES_I = 1'b1;
      step();
      checkOutput("reset_in_pop", {27'b0, CYC_O, STB_O, WE_O, ADR_O, EV_VALID_O}, 32'd0);
      RES_I = 1'b0;
      modelReset();
      exp_q.delete();
      for (int p = rd_ptr; p < wr_ptr; p++) modelByte(mem[p[7:0]]);
      step();
      checkOutput("resume_stat", {30'b0, STB_O, ADR_O}, 32'd2);
      drain();

      // Random byte streams.
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < 40; i++) applyStimulus(randomByte(), 1);
         drain();
      end

      checkOutput("pop_on_empty", bad_pops, 32'd0);
      checkOutput("pop_total", pop_count, wr_ptr);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
